// File: rtl/ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : ex_muldiv_unit
// Description : Iterative RV32M multiply/divide engine for the EX stage.
//               Radix-2 shift-add multiply, restoring divide, one bit/cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            START,
    input  logic            FLUSH,
    input  logic [2:0]      FUNC3_IN,
    input  logic [XLEN-1:0] DATA1_IN,
    input  logic [XLEN-1:0] DATA2_IN,
    input  logic [4:0]      RD_IN,
    output logic            BUSY,
    output logic            DONE,
    output logic [XLEN-1:0] RESULT,
    output logic [4:0]      RD_OUT
);
    localparam int CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  c_int_min  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_FINISH  = 2'd2,
        S_SPECIAL = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [2:0]          r_func3;
    logic [4:0]          r_rd;
    logic                r_neg_a;
    logic                r_neg_b;
    logic [XLEN-1:0]     r_hi;
    logic [XLEN-1:0]     r_lo;
    logic [XLEN-1:0]     r_opb;
    logic                r_done;
    logic [XLEN-1:0]     r_result;
    logic [4:0]          r_rd_out;

    // Operand decode at launch
    logic                w_is_div;
    logic                w_signed_a;
    logic                w_signed_b;
    logic                w_neg_a;
    logic                w_neg_b;
    logic [XLEN-1:0]     w_abs_a;
    logic [XLEN-1:0]     w_abs_b;
    logic                w_div_zero;
    logic                w_overflow;
    logic                w_special;
    logic [XLEN-1:0]     w_special_val;

    assign w_is_div   = FUNC3_IN[2];
    assign w_signed_a = w_is_div ? ~FUNC3_IN[0] : ~(FUNC3_IN[1] & FUNC3_IN[0]);
    assign w_signed_b = w_is_div ? ~FUNC3_IN[0] : ~FUNC3_IN[1];
    assign w_neg_a    = w_signed_a & DATA1_IN[XLEN-1];
    assign w_neg_b    = w_signed_b & DATA2_IN[XLEN-1];
    assign w_abs_a    = w_neg_a ? -DATA1_IN : DATA1_IN;
    assign w_abs_b    = w_neg_b ? -DATA2_IN : DATA2_IN;
    assign w_div_zero = w_is_div && (DATA2_IN == '0);
    assign w_overflow = w_is_div && !FUNC3_IN[0] && (DATA1_IN == c_int_min) && (DATA2_IN == '1);
    assign w_special  = w_div_zero || w_overflow;

    // FUNC3_IN[1] separates REM* from DIV*
    always_comb begin
        w_special_val = '0;
        if (w_div_zero)
            w_special_val = FUNC3_IN[1] ? DATA1_IN : '1;
        else if (w_overflow)
            w_special_val = FUNC3_IN[1] ? '0 : c_int_min;
    end

    // Iteration datapath: r_hi is the partial product / partial remainder,
    // r_lo holds the multiplier bits being consumed or the quotient being built.
    logic [XLEN:0]       w_sum;
    logic [XLEN:0]       w_shift;
    logic [XLEN-1:0]     w_diff;
    logic                w_ge;

    assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : '0);
    assign w_shift = {r_hi, r_lo[XLEN-1]};
    assign w_ge    = (w_shift >= {1'b0, r_opb});
    assign w_diff  = w_shift[XLEN-1:0] - r_opb;

    // Sign correction and result selection
    logic [2*XLEN-1:0]   w_prod;
    logic [2*XLEN-1:0]   w_prod_s;
    logic [XLEN-1:0]     w_quo_s;
    logic [XLEN-1:0]     w_rem_s;
    logic [XLEN-1:0]     w_final;

    assign w_prod   = {r_hi, r_lo};
    assign w_prod_s = (r_neg_a ^ r_neg_b) ? -w_prod : w_prod;
    assign w_quo_s  = (r_neg_a ^ r_neg_b) ? -r_lo : r_lo;
    assign w_rem_s  = r_neg_a ? -r_hi : r_hi;

    always_comb begin
        w_final = '0;
        case (r_func3)
            3'b000:                 w_final = w_prod_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: w_final = w_prod_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         w_final = w_quo_s;
            default:                w_final = w_rem_s;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET)
            r_state <= S_IDLE;
        else
            r_state <= w_next_state;
    end

    // FLUSH overrides every transition, including completion
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:    if (START) w_next_state = w_special ? S_SPECIAL : S_RUN;
            S_RUN:     if (r_cnt == c_last_cnt) w_next_state = S_FINISH;
            S_FINISH:  w_next_state = S_IDLE;
            S_SPECIAL: w_next_state = S_IDLE;
        endcase
        if (FLUSH)
            w_next_state = S_IDLE;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_cnt    <= '0;
            r_func3  <= '0;
            r_rd     <= '0;
            r_neg_a  <= 1'b0;
            r_neg_b  <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_opb    <= '0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_rd_out <= '0;
        end else begin
            r_done <= 1'b0;
            if (!FLUSH) begin
                case (r_state)
                    S_IDLE: if (START) begin
                        r_cnt   <= '0;
                        r_func3 <= FUNC3_IN;
                        r_rd    <= RD_IN;
                        r_neg_a <= w_neg_a;
                        r_neg_b <= w_neg_b;
                        r_hi    <= '0;
                        r_lo    <= w_special ? w_special_val : w_abs_a;
                        r_opb   <= w_abs_b;
                    end
                    S_RUN: begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_func3[2]) begin
                            r_hi <= w_ge ? w_diff : w_shift[XLEN-1:0];
                            r_lo <= {r_lo[XLEN-2:0], w_ge};
                        end else begin
                            r_hi <= w_sum[XLEN:1];
                            r_lo <= {w_sum[0], r_lo[XLEN-1:1]};
                        end
                    end
                    S_FINISH: begin
                        r_done   <= 1'b1;
                        r_result <= w_final;
                        r_rd_out <= r_rd;
                    end
                    S_SPECIAL: begin
                        r_done   <= 1'b1;
                        r_result <= r_lo;
                        r_rd_out <= r_rd;
                    end
                endcase
            end
        end
    end

    assign BUSY   = (r_state != S_IDLE);
    assign DONE   = r_done;
    assign RESULT = r_result;
    assign RD_OUT = r_rd_out;

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_muldiv_unit
// Description : Directed and randomized self-checking bench for ex_muldiv_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_muldiv_unit;
    logic        CLK;
    logic        RESET;
    logic        START;
    logic        FLUSH;
    logic [2:0]  FUNC3_IN;
    logic [31:0] DATA1_IN;
    logic [31:0] DATA2_IN;
    logic [4:0]  RD_IN;
    logic        BUSY;
    logic        DONE;
    logic [31:0] RESULT;
    logic [4:0]  RD_OUT;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] last_res = '0;
    logic [4:0]  last_rd  = '0;

    ex_muldiv_unit #(.XLEN(32)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .START    (START),
        .FLUSH    (FLUSH),
        .FUNC3_IN (FUNC3_IN),
        .DATA1_IN (DATA1_IN),
        .DATA2_IN (DATA2_IN),
        .RD_IN    (RD_IN),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .RESULT   (RESULT),
        .RD_OUT   (RD_OUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Arithmetic reference: 64-bit integer math straight from the RV32M rules
    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ua, ub, q;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        case (f)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                q = sa / sb; return q[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                q = sa % sb; return q[31:0];
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && (b == 0)) return 1;
        if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Launch one op (DUT idle, just after an edge) and wait for its DONE
    task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp, input int exp_lat, input bit chk_busy);
        int cyc;
        int busy_cnt;
        START = 1'b1; FUNC3_IN = f; DATA1_IN = a; DATA2_IN = b; RD_IN = rd;
        step();
        START = 1'b0;
        cyc = 0;
        busy_cnt = 0;
        while (!DONE && cyc < 100) begin
            if (BUSY) busy_cnt++;
            step();
            cyc++;
        end
        check({tag, "_done_seen"}, {63'b0, DONE}, 64'd1);
        check({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
        check({tag, "_result"}, {32'b0, RESULT}, {32'b0, exp});
        check({tag, "_rd"}, {59'b0, RD_OUT}, {59'b0, rd});
        if (chk_busy) begin
            check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd33);
            check({tag, "_busy_low_at_done"}, {63'b0, BUSY}, 64'd0);
        end
        last_res = exp;
        last_rd  = rd;
    endtask

    task automatic no_done_window(input string tag, input int n);
        int seen;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (DONE) seen++;
        end
        check({tag, "_no_done"}, 64'(seen), 64'd0);
        check({tag, "_idle"}, {63'b0, BUSY}, 64'd0);
    endtask

    // Launch an op, raise FLUSH after n further edges, expect a silent abort
    task automatic flush_at(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input int n);
        START = 1'b1; FUNC3_IN = f; DATA1_IN = a; DATA2_IN = b; RD_IN = 5'd30;
        step();
        START = 1'b0;
        for (int i = 0; i < n; i++) step();
        check({tag, "_busy_before"}, {63'b0, BUSY}, 64'd1);
        FLUSH = 1'b1;
        step();
        FLUSH = 1'b0;
        check({tag, "_busy"}, {63'b0, BUSY}, 64'd0);
        check({tag, "_done"}, {63'b0, DONE}, 64'd0);
        check({tag, "_result_held"}, {32'b0, RESULT}, {32'b0, last_res});
        check({tag, "_rd_held"}, {59'b0, RD_OUT}, {59'b0, last_rd});
        no_done_window(tag, 40);
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [2:0]  f;
        logic [31:0] a, b;
        logic [4:0]  rd;
        int          cyc;
        int          dones;

        RESET = 1'b1; START = 1'b0; FLUSH = 1'b0;
        FUNC3_IN = '0; DATA1_IN = '0; DATA2_IN = '0; RD_IN = '0;
        repeat (3) step();
        RESET = 1'b0;
        check("reset_busy", {63'b0, BUSY}, 64'd0);
        check("reset_done", {63'b0, DONE}, 64'd0);
        check("reset_result", {32'b0, RESULT}, 64'd0);
        check("reset_rd", {59'b0, RD_OUT}, 64'd0);
        step();

        // Directed arithmetic cases
        do_op("mul_7xm3", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 33, 1'b1);
        step();
        check("done_one_cycle", {63'b0, DONE}, 64'd0);
        check("result_held", {32'b0, RESULT}, 64'hFFFF_FFEB);
        do_op("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000, 5'd6, 32'h4000_0000, 33, 1'b0);
        do_op("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFE, 33, 1'b0);
        do_op("mulhsu_m1x2", 3'd2, 32'hFFFF_FFFF, 32'd2, 5'd8, 32'hFFFF_FFFF, 33, 1'b0);
        do_op("divu_by0", 3'd5, 32'd100, 32'd0, 5'd9, 32'hFFFF_FFFF, 1, 1'b0);
        do_op("remu_by0", 3'd7, 32'd100, 32'd0, 5'd10, 32'd100, 1, 1'b0);
        do_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1, 1'b0);
        do_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h0, 1, 1'b0);
        do_op("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd13, 32'hFFFF_FFFD, 33, 1'b0);
        do_op("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd14, 32'hFFFF_FFFF, 33, 1'b0);
        do_op("divu_big", 3'd5, 32'hFFFF_FFFE, 32'd3, 5'd15, 32'h5555_5554, 33, 1'b0);
        step();

        // Aborts: mid-run, in the completion cycles, and FLUSH+START while idle
        flush_at("flush_run10", 3'd0, 32'd123, 32'd456, 10);
        flush_at("flush_finish", 3'd5, 32'd1000, 32'd7, 32);
        flush_at("flush_special", 3'd4, 32'd5, 32'd0, 0);
        START = 1'b1; FLUSH = 1'b1; FUNC3_IN = 3'd0; DATA1_IN = 32'd3; DATA2_IN = 32'd3;
        step();
        START = 1'b0; FLUSH = 1'b0;
        check("flush_start_idle_busy", {63'b0, BUSY}, 64'd0);
        no_done_window("flush_start_idle", 40);

        // START pulsed while busy must be ignored
        START = 1'b1; FUNC3_IN = 3'd0; DATA1_IN = 32'd3; DATA2_IN = 32'd5; RD_IN = 5'd21;
        step();
        START = 1'b0;
        repeat (5) step();
        START = 1'b1; FUNC3_IN = 3'd5; DATA1_IN = 32'd9; DATA2_IN = 32'd0; RD_IN = 5'd22;
        step();
        START = 1'b0;
        cyc = 6;
        while (!DONE && cyc < 100) begin step(); cyc++; end
        check("start_busy_latency", 64'(cyc), 64'd33);
        check("start_busy_result", {32'b0, RESULT}, 64'd15);
        check("start_busy_rd", {59'b0, RD_OUT}, 64'd21);
        last_res = 32'd15; last_rd = 5'd21;
        no_done_window("start_busy_single", 40);

        // Reset in the middle of a run
        START = 1'b1; FUNC3_IN = 3'd1; DATA1_IN = 32'h1234_5678; DATA2_IN = 32'h9ABC_DEF0; RD_IN = 5'd3;
        step();
        START = 1'b0;
        repeat (5) step();
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        check("rst_mid_busy", {63'b0, BUSY}, 64'd0);
        check("rst_mid_done", {63'b0, DONE}, 64'd0);
        check("rst_mid_result", {32'b0, RESULT}, 64'd0);
        check("rst_mid_rd", {59'b0, RD_OUT}, 64'd0);
        last_res = '0; last_rd = '0;
        no_done_window("rst_mid", 40);

        // Back-to-back, each next START issued in the previous DONE cycle
        do_op("b2b_a", 3'd0, 32'd11, 32'd13, 5'd1, 32'd143, 33, 1'b0);
        do_op("b2b_b", 3'd7, 32'd143, 32'd10, 5'd2, 32'd3, 33, 1'b0);
        do_op("b2b_c", 3'd5, 32'd143, 32'd0, 5'd4, 32'hFFFF_FFFF, 1, 1'b0);

        // Randomized ops against the arithmetic reference
        for (int i = 0; i < 40; i++) begin
            f  = 3'($urandom_range(0, 7));
            a  = rnd_operand();
            b  = rnd_operand();
            rd = 5'($urandom_range(0, 31));
            do_op($sformatf("rnd%0d_f%0d_%h_%h", i, f, a, b), f, a, b, rd, ref_model(f, a, b), ref_latency(f, a, b), 1'b0);
            if ($urandom_range(0, 1) == 1) step();
        end

        dones = 0;
        repeat (5) begin step(); if (DONE) dones++; end
        check("final_quiet", 64'(dones), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
